// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
// Holds the serialiser state encoding and default frame geometry.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int DVSR_W      = 11;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int FIFO_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running 16x oversample tick generator.
// Tick period is dvsr+1 clocks; a new divisor applies at the next compare.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [DVSR_W-1:0] dvsr_i,
  output logic              tick_o
);

  localparam logic [DVSR_W-1:0] CNT_ONE = DVSR_W'(1);

  logic [DVSR_W-1:0] cnt_q;
  logic [DVSR_W-1:0] cnt_d;

  assign tick_o = (cnt_q >= dvsr_i);
  assign cnt_d  = tick_o ? '0 : cnt_q + CNT_ONE;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_path.sv
// uart_tx_path: byte FIFO plus 8N1 serialiser driven by the baud tick.
// The FIFO and the transmit FSM live here; the tick comes from uart_baud_gen.
module uart_tx_path
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int FIFO_W  = FIFO_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_uart,
  input  logic [DBIT-1:0]   w_data,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              tx_busy,
  output logic              tx
);

  localparam int DEPTH = 1 << FIFO_W;
  // Longer stop periods (1.5 / 2 bits) need a wider sample counter
  localparam int S_W = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [S_W-1:0]    S_ONE     = S_W'(1);
  localparam logic [S_W-1:0]    S_OS_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0]    S_SB_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0]    N_ONE     = N_W'(1);
  localparam logic [N_W-1:0]    N_LAST    = N_W'(DBIT - 1);
  localparam logic [FIFO_W-1:0] PTR_ONE   = FIFO_W'(1);
  localparam logic [FIFO_W:0]   CNT_ONE   = (FIFO_W + 1)'(1);
  localparam logic [FIFO_W:0]   CNT_FULL  = (FIFO_W + 1)'(DEPTH);

  logic tick;

  uart_baud_gen u_baud (
    .clk    (clk),
    .resetn (resetn),
    .dvsr_i (dvsr),
    .tick_o (tick)
  );

  logic [DBIT-1:0]   mem_q [DEPTH];
  logic [FIFO_W-1:0] wr_ptr_q;
  logic [FIFO_W-1:0] rd_ptr_q;
  logic [FIFO_W:0]   count_q;
  logic [FIFO_W:0]   count_d;
  logic              full_q;
  logic              empty_q;
  logic              push;
  logic              pop;

  tx_state_e         state_q;
  logic [S_W-1:0]    s_q;
  logic [N_W-1:0]    n_q;
  logic [DBIT-1:0]   b_q;
  logic              tx_q;
  logic              busy_q;

  assign push = wr_uart && !full_q;
  assign pop  = (state_q == ST_IDLE) && !empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  // tx_q is loaded with the level of the state being entered
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!empty_q) begin
            b_q     <= mem_q[rd_ptr_q];
            s_q     <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (s_q == S_OS_LAST) begin
              s_q     <= '0;
              n_q     <= '0;
              tx_q    <= b_q[0];
              state_q <= ST_DATA;
            end else begin
              s_q <= s_q + S_ONE;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (s_q == S_OS_LAST) begin
              s_q <= '0;
              b_q <= {1'b0, b_q[DBIT-1:1]};
              if (n_q == N_LAST) begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end else begin
                n_q  <= n_q + N_ONE;
                tx_q <= b_q[1];
              end
            end else begin
              s_q <= s_q + S_ONE;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (s_q == S_SB_LAST) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              s_q <= s_q + S_ONE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_full  = full_q;
  assign tx_empty = empty_q;
  assign tx_busy  = busy_q;
  assign tx       = tx_q;

endmodule
